synaptic_integrator: RTL

- Stage directly upstream of the LIF neuron. Produces the neuron's 16-bit FP16 `input_current` once per timestep.
- Accepts presynaptic spike events as addresses and queues them in an event FIFO.
- For each event, looks up an FP16 synaptic weight and accumulates it with the team's combinational FP16 adder (floatAdd).
- On a timestep boundary pulse, drains the queue, presents the sum with a one-cycle valid, then clears the accumulator.

---
 rtl/synaptic_integrator.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/synaptic_integrator.sv
// Event-driven FP16 synaptic current integrator feeding the LIF neuron.
// Optional macro SYN_CLAMP_EN: saturate an overflowing accumulator to +/-65504 instead of Inf.
module synaptic_integrator #(
    parameter int N_PRE      = 16,
    parameter int ADDR_W     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spike_valid,
    input  logic [ADDR_W-1:0] spike_addr,
    output logic              spike_ready,
    input  logic              step,
    input  logic              w_we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [15:0]       w_data,
    output logic [15:0]       input_current,
    output logic              current_valid,
    output logic              busy
);

    localparam int DATA_W = 16;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, ADD, EMIT} state_t;

    state_t              state;
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]   w_mem [N_PRE];
    logic [DATA_W-1:0]   weight_p1;
    logic [DATA_W-1:0]   w_reg;
    logic [DATA_W-1:0]   acc;
    logic                step_pending;
    logic                fifo_empty, fifo_full, push, pop;
    logic [ADDR_W-1:0]   head_addr;

    // FP16 add, round-to-nearest-even; subnormals kept, NaN canonicalised.
    function automatic logic [15:0] float_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y;
        logic [6:0]  ex, ey, e, d;
        logic [13:0] mx, my, shifted;
        logic [14:0] sum;
        logic        sticky, rnd;
        logic [11:0] mr;
        if ((&a[14:10]) && (|a[9:0])) return 16'h7E00;
        if ((&b[14:10]) && (|b[9:0])) return 16'h7E00;
        if (&a[14:10]) begin
            if ((&b[14:10]) && (a[15] != b[15])) return 16'h7E00;
            return a;
        end
        if (&b[14:10]) return b;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        ex = (x[14:10] == 5'd0) ? 7'd1 : {2'b00, x[14:10]};
        ey = (y[14:10] == 5'd0) ? 7'd1 : {2'b00, y[14:10]};
        mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
        d  = ex - ey;
        if (d > 7'd13) begin
            shifted = 14'd0;
            sticky  = |my;
        end else begin
            shifted = my >> d;
            sticky  = |(my & ((14'd1 << d) - 14'd1));
        end
        shifted[0] = shifted[0] | sticky;
        e = ex;
        if (x[15] == y[15]) begin
            sum = {1'b0, mx} + {1'b0, shifted};
            if (sum[14]) begin
                sum = {1'b0, sum[14:2], sum[1] | sum[0]};
                e   = e + 7'd1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, shifted};
            if (sum == 15'd0) return 16'h0000;
            for (int i = 0; i < 14; i++) begin
                if (!sum[13] && (e > 7'd1)) begin
                    sum = sum << 1;
                    e   = e - 7'd1;
                end
            end
        end
        rnd = sum[2] && (sum[1] || sum[0] || sum[3]);
        mr  = {1'b0, sum[13:3]} + {11'd0, rnd};
        if (mr[11]) begin
            mr = mr >> 1;
            e  = e + 7'd1;
        end
        if (e >= 7'd31) return {x[15], 5'h1F, 10'h000};
        return {x[15], (mr[10] ? e[4:0] : 5'd0), mr[9:0]};
    endfunction

    function automatic logic [15:0] saturate(input logic [15:0] r);
`ifdef SYN_CLAMP_EN
        if (r[14:10] == 5'h1F) return r[15] ? 16'hFBFF : 16'h7BFF;
`endif
        return r;
    endfunction

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign spike_ready = !fifo_full && !step_pending && reset;
    assign push        = spike_valid && spike_ready;
    assign pop         = (state == IDLE) && !fifo_empty;
    assign head_addr   = fifo_mem[rd_ptr[PTR_W-1:0]];
    assign busy        = (state != IDLE) || !fifo_empty || step_pending;

    // Storage: event queue, weight memory and its read port hold no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= spike_addr;
        if (w_we) w_mem[w_addr] <= w_data;
        if (pop) weight_p1 <= w_mem[head_addr];
        if (state == FETCH) w_reg <= weight_p1;
    end

    // Control FSM and accumulator.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            step_pending  <= 1'b0;
            acc           <= 16'h0000;
            input_current <= 16'h0000;
            current_valid <= 1'b0;
        end else begin
            current_valid <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (step) step_pending <= 1'b1;
            case (state)
                IDLE: begin
                    if (step_pending && fifo_empty) begin
                        state <= EMIT;
                    end else if (!fifo_empty) begin
                        rd_ptr <= rd_ptr + 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: state <= ADD;
                ADD: begin
                    acc   <= saturate(float_add(acc, w_reg));
                    state <= IDLE;
                end
                EMIT: begin
                    input_current <= acc;
                    current_valid <= 1'b1;
                    acc           <= 16'h0000;
                    step_pending  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
